// File: rtl/graphic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : graphic_pkg
// Purpose  : Lane codes, start positions, end thresholds and move direction
//            shared by the play-screen note sequencing blocks.
// Revision : 1.0
// ============================================================================
package graphic_pkg;

  localparam logic [1:0] LANE_R = 2'd0;
  localparam logic [1:0] LANE_G = 2'd1;
  localparam logic [1:0] LANE_B = 2'd2;
  localparam logic [1:0] LANE_Y = 2'd3;

  localparam int START_R = 0;
  localparam int START_G = 479;
  localparam int START_B = 639;
  localparam int START_Y = 0;

  localparam int R_END_DEF = 240;
  localparam int G_END_DEF = 240;
  localparam int B_END_DEF = 320;
  localparam int Y_END_DEF = 320;

  typedef enum logic {
    INC = 1'b0,
    DEC = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/note_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler_if
// Purpose  : Spawn handshake, judge pulses and position/go buses between the
//            chart player, the note scheduler and the graphic block.
// Revision : 1.0
// ============================================================================
interface note_scheduler_if;

  logic       run;
  logic       frame_tick;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_ready;
  logic [3:0] hit;
  logic [3:0] hit_ok;
  logic [3:0] miss;
  logic [9:0] raddy, gaddy, baddx, yaddx;
  logic       rgo, ggo, bgo, ygo;
  logic [9:0] r2addy, g2addy, b2addx, y2addx;
  logic       r2go, g2go, b2go, y2go;

  modport master (
    output run, frame_tick, spawn_valid, spawn_lane, hit,
    input  spawn_ready, hit_ok, miss,
    input  raddy, gaddy, baddx, yaddx, rgo, ggo, bgo, ygo,
    input  r2addy, g2addy, b2addx, y2addx, r2go, g2go, b2go, y2go
  );

  modport slave (
    input  run, frame_tick, spawn_valid, spawn_lane, hit,
    output spawn_ready, hit_ok, miss,
    output raddy, gaddy, baddx, yaddx, rgo, ggo, bgo, ygo,
    output r2addy, g2addy, b2addx, y2addx, r2go, g2go, b2go, y2go
  );

endinterface
`default_nettype wire

// File: rtl/note_scheduler_lane.sv
`default_nettype none
// ============================================================================
// Module   : note_lane
// Purpose  : One lane of falling notes: two slots, oldest pointer, hit/miss.
// Revision : 1.0
// ============================================================================
module note_lane
  import graphic_pkg::*;
#(
  parameter int   START = 0,
  parameter int   END   = 240,
  parameter dir_e DIR   = INC,
  parameter int   SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_frame_tick,
  input  logic       i_spawn_valid,
  input  logic       i_hit,
  output logic       o_spawn_ready,
  output logic       o_hit_ok,
  output logic       o_miss,
  output logic [9:0] o_pos0,
  output logic [9:0] o_pos1,
  output logic       o_go0,
  output logic       o_go1
);

  localparam logic [10:0] c_speed = 11'(SPEED);
  localparam logic [10:0] c_end   = 11'(END);
  localparam logic [9:0]  c_start = 10'(START);

  logic [9:0]  r_pos [2];
  logic [1:0]  r_go;
  logic        r_oldest;
  logic        r_hit_ok;
  logic        r_miss;

  logic [9:0]  w_nxt_pos [2];
  logic [10:0] w_adv [2];
  logic [1:0]  w_nxt_go, w_hit_ret, w_miss, w_at_end, w_surv;
  logic        w_accept, w_spawn_slot, w_hit_slot, w_nxt_oldest;

  assign o_spawn_ready = i_run & ~(&r_go);
  assign w_accept      = i_spawn_valid & o_spawn_ready;
  assign w_spawn_slot  = r_go[0];
  // Pointer only goes stale when the lane is empty; fall back to the live slot.
  assign w_hit_slot    = r_go[r_oldest] ? r_oldest : ~r_oldest;

  always_comb begin
    w_nxt_go  = r_go;
    w_hit_ret = '0;
    w_miss    = '0;
    w_at_end  = '0;
    for (int s = 0; s < 2; s++) begin
      w_nxt_pos[s] = r_pos[s];
      if (DIR == INC) begin
        w_adv[s]    = {1'b0, r_pos[s]} + c_speed;
        w_at_end[s] = (w_adv[s] >= c_end);
      end else begin
        w_adv[s]    = {1'b0, r_pos[s]} - c_speed;
        w_at_end[s] = ({1'b0, r_pos[s]} <= c_end + c_speed);
      end
      w_hit_ret[s] = i_hit & r_go[s] & (w_hit_slot == 1'(s));
      if (w_hit_ret[s]) begin
        w_nxt_go[s]  = 1'b0;
        w_nxt_pos[s] = c_start;
      end else if (r_go[s] & i_frame_tick) begin
        if (w_at_end[s]) begin
          w_miss[s]    = 1'b1;
          w_nxt_go[s]  = 1'b0;
          w_nxt_pos[s] = c_start;
        end else begin
          w_nxt_pos[s] = w_adv[s][9:0];
        end
      end
    end
    w_surv = r_go & w_nxt_go;
    // Spawn lands in a slot that was free before the edge, so it never moves.
    if (w_accept) begin
      w_nxt_go[w_spawn_slot]  = 1'b1;
      w_nxt_pos[w_spawn_slot] = c_start;
    end
  end

  always_comb begin
    w_nxt_oldest = r_oldest;
    if (!w_surv[r_oldest]) begin
      if (w_surv[~r_oldest]) begin
        w_nxt_oldest = ~r_oldest;
      end else if (w_accept) begin
        w_nxt_oldest = w_spawn_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_go     <= '0;
      r_pos[0] <= c_start;
      r_pos[1] <= c_start;
      r_oldest <= 1'b0;
      r_hit_ok <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_go     <= w_nxt_go;
      r_pos[0] <= w_nxt_pos[0];
      r_pos[1] <= w_nxt_pos[1];
      r_oldest <= w_nxt_oldest;
      r_hit_ok <= i_hit & (|r_go);
      r_miss   <= |w_miss;
    end
  end

  assign o_pos0   = r_pos[0];
  assign o_pos1   = r_pos[1];
  assign o_go0    = r_go[0];
  assign o_go1    = r_go[1];
  assign o_hit_ok = r_hit_ok;
  assign o_miss   = r_miss;

endmodule
`default_nettype wire

// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Purpose  : Four-lane falling-note sequencer feeding the graphic datapath.
// Revision : 1.0
// ============================================================================
module note_scheduler
  import graphic_pkg::*;
#(
  parameter int SPEED = 2,
  parameter int R_END = R_END_DEF,
  parameter int G_END = G_END_DEF,
  parameter int B_END = B_END_DEF,
  parameter int Y_END = Y_END_DEF
) (
  input  logic             PCK,
  input  logic             RST,
  note_scheduler_if.slave  bus
);

  logic [3:0] w_valid, w_ready, w_hit_ok, w_miss;

  assign w_valid         = bus.spawn_valid ? (4'b0001 << bus.spawn_lane) : 4'b0000;
  assign bus.spawn_ready = w_ready[bus.spawn_lane];
  assign bus.hit_ok      = w_hit_ok;
  assign bus.miss        = w_miss;

  note_lane #(.START(START_R), .END(R_END), .DIR(INC), .SPEED(SPEED)) u_lane_r (
    .clk(PCK), .rst(RST), .i_run(bus.run), .i_frame_tick(bus.frame_tick),
    .i_spawn_valid(w_valid[LANE_R]), .i_hit(bus.hit[LANE_R]),
    .o_spawn_ready(w_ready[LANE_R]), .o_hit_ok(w_hit_ok[LANE_R]), .o_miss(w_miss[LANE_R]),
    .o_pos0(bus.raddy), .o_pos1(bus.r2addy), .o_go0(bus.rgo), .o_go1(bus.r2go)
  );

  note_lane #(.START(START_G), .END(G_END), .DIR(DEC), .SPEED(SPEED)) u_lane_g (
    .clk(PCK), .rst(RST), .i_run(bus.run), .i_frame_tick(bus.frame_tick),
    .i_spawn_valid(w_valid[LANE_G]), .i_hit(bus.hit[LANE_G]),
    .o_spawn_ready(w_ready[LANE_G]), .o_hit_ok(w_hit_ok[LANE_G]), .o_miss(w_miss[LANE_G]),
    .o_pos0(bus.gaddy), .o_pos1(bus.g2addy), .o_go0(bus.ggo), .o_go1(bus.g2go)
  );

  note_lane #(.START(START_B), .END(B_END), .DIR(DEC), .SPEED(SPEED)) u_lane_b (
    .clk(PCK), .rst(RST), .i_run(bus.run), .i_frame_tick(bus.frame_tick),
    .i_spawn_valid(w_valid[LANE_B]), .i_hit(bus.hit[LANE_B]),
    .o_spawn_ready(w_ready[LANE_B]), .o_hit_ok(w_hit_ok[LANE_B]), .o_miss(w_miss[LANE_B]),
    .o_pos0(bus.baddx), .o_pos1(bus.b2addx), .o_go0(bus.bgo), .o_go1(bus.b2go)
  );

  note_lane #(.START(START_Y), .END(Y_END), .DIR(INC), .SPEED(SPEED)) u_lane_y (
    .clk(PCK), .rst(RST), .i_run(bus.run), .i_frame_tick(bus.frame_tick),
    .i_spawn_valid(w_valid[LANE_Y]), .i_hit(bus.hit[LANE_Y]),
    .o_spawn_ready(w_ready[LANE_Y]), .o_hit_ok(w_hit_ok[LANE_Y]), .o_miss(w_miss[LANE_Y]),
    .o_pos0(bus.yaddx), .o_pos1(bus.y2addx), .o_go0(bus.ygo), .o_go1(bus.y2go)
  );

endmodule
`default_nettype wire

// File: tb/tb_note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_scheduler
// Purpose  : Directed and random stimulus against a queue-based lane model.
// Revision : 1.0
// ============================================================================
module tb_note_scheduler;

  localparam int SPEED = 2;

  logic PCK = 1'b0;
  logic RST = 1'b1;
  always #5 PCK = ~PCK;

  note_scheduler_if bus();

  note_scheduler #(
    .SPEED(SPEED), .R_END(240), .G_END(240), .B_END(320), .Y_END(320)
  ) dut (
    .PCK(PCK), .RST(RST), .bus(bus)
  );

  int c_start [4] = '{0, 479, 639, 0};
  int c_dir   [4] = '{1, -1, -1, 1};
  int c_end   [4] = '{240, 240, 320, 320};

  // Model: each slot's position/state, plus a per-lane age queue of slot ids.
  int         mpos [4][2];
  bit         mgo  [4][2];
  int         q    [4][$];
  logic [3:0] exp_hit_ok = '0;
  logic [3:0] exp_miss   = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < 2; s++) begin
        mgo[l][s]  = 1'b0;
        mpos[l][s] = c_start[l];
      end
      q[l].delete();
    end
  endtask

  task automatic model_step(input bit rst_i, input bit run_i, input bit tick_i,
                            input bit sv_i, input logic [1:0] sl_i, input logic [3:0] hit_i);
    exp_hit_ok = '0;
    exp_miss   = '0;
    if (rst_i || !run_i) begin
      model_clear();
    end else begin
      for (int l = 0; l < 4; l++) begin
        int n, tgt, fr, np;
        bit acc;
        n   = q[l].size();
        acc = sv_i && (sl_i == 2'(l)) && (n < 2);
        fr  = mgo[l][0] ? 1 : 0;
        tgt = -1;
        if (hit_i[l] && n > 0) begin
          tgt = q[l][0];
          exp_hit_ok[l] = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
          if (mgo[l][s]) begin
            if (s == tgt) begin
              mgo[l][s] = 1'b0; mpos[l][s] = c_start[l];
            end else if (tick_i) begin
              np = mpos[l][s] + c_dir[l] * SPEED;
              if ((c_dir[l] > 0 && np >= c_end[l]) || (c_dir[l] < 0 && np <= c_end[l])) begin
                mgo[l][s] = 1'b0; mpos[l][s] = c_start[l];
                exp_miss[l] = 1'b1;
              end else begin
                mpos[l][s] = np;
              end
            end
          end
        end
        for (int i = q[l].size() - 1; i >= 0; i--)
          if (!mgo[l][q[l][i]]) q[l].delete(i);
        if (acc) begin
          mgo[l][fr]  = 1'b1;
          mpos[l][fr] = c_start[l];
          q[l].push_back(fr);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [9:0] p0 [4];
    logic [9:0] p1 [4];
    logic       g0 [4];
    logic       g1 [4];
    p0 = '{bus.raddy, bus.gaddy, bus.baddx, bus.yaddx};
    p1 = '{bus.r2addy, bus.g2addy, bus.b2addx, bus.y2addx};
    g0 = '{bus.rgo, bus.ggo, bus.bgo, bus.ygo};
    g1 = '{bus.r2go, bus.g2go, bus.b2go, bus.y2go};
    for (int l = 0; l < 4; l++) begin
      check($sformatf("pos0_lane%0d", l), 32'(p0[l]), 32'(mpos[l][0]));
      check($sformatf("pos1_lane%0d", l), 32'(p1[l]), 32'(mpos[l][1]));
      check($sformatf("go0_lane%0d", l),  32'(g0[l]), 32'(mgo[l][0]));
      check($sformatf("go1_lane%0d", l),  32'(g1[l]), 32'(mgo[l][1]));
    end
    check("hit_ok", 32'(bus.hit_ok), 32'(exp_hit_ok));
    check("miss",   32'(bus.miss),   32'(exp_miss));
  endtask

  // One clock: drive, check combinational ready, advance model, check outputs.
  task automatic cycle(input bit rst_i, input bit run_i, input bit tick_i,
                       input bit sv_i, input logic [1:0] sl_i, input logic [3:0] hit_i);
    RST             = rst_i;
    bus.run         = run_i;
    bus.frame_tick  = tick_i;
    bus.spawn_valid = sv_i;
    bus.spawn_lane  = sl_i;
    bus.hit         = hit_i;
    #1;
    check("spawn_ready", 32'(bus.spawn_ready), 32'(run_i && (q[sl_i].size() < 2)));
    model_step(rst_i, run_i, tick_i, sv_i, sl_i, hit_i);
    @(posedge PCK);
    #1;
    compare_all();
  endtask

  initial begin
    model_clear();
    cycle(1, 0, 0, 0, 2'd0, 4'b0000);
    cycle(1, 1, 1, 1, 2'd0, 4'b1111);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Red note flies to the lane end and misses.
    cycle(0, 1, 0, 1, 2'd0, 4'b0000);
    repeat (120) cycle(0, 1, 1, 0, 2'd0, 4'b0000);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Green fills both slots; the third request waits for a hit.
    cycle(0, 1, 0, 1, 2'd1, 4'b0000);
    cycle(0, 1, 1, 0, 2'd1, 4'b0000);
    cycle(0, 1, 0, 1, 2'd1, 4'b0000);
    repeat (3) cycle(0, 1, 0, 1, 2'd1, 4'b0000);
    cycle(0, 1, 0, 1, 2'd1, 4'b0010);
    cycle(0, 1, 0, 1, 2'd1, 4'b0000);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Blue: second note spawned on the tenth tick, then the first is hit.
    cycle(0, 1, 0, 1, 2'd2, 4'b0000);
    repeat (9) cycle(0, 1, 1, 0, 2'd0, 4'b0000);
    cycle(0, 1, 1, 1, 2'd2, 4'b0000);
    check("blue_first_at_619", 32'(bus.baddx), 32'd619);
    cycle(0, 1, 0, 0, 2'd0, 4'b0100);
    cycle(0, 1, 1, 0, 2'd0, 4'b0100);

    // Hit on an empty yellow lane.
    cycle(0, 1, 0, 0, 2'd0, 4'b1000);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Red one step from the end: hit and tick together.
    cycle(0, 1, 0, 1, 2'd0, 4'b0000);
    repeat (119) cycle(0, 1, 1, 0, 2'd0, 4'b0000);
    check("red_one_step_from_end", 32'(bus.raddy), 32'd238);
    cycle(0, 1, 1, 0, 2'd0, 4'b0001);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Spawn with a coincident tick, then drop run with a spawn in flight.
    cycle(0, 1, 1, 1, 2'd3, 4'b0000);
    repeat (5) cycle(0, 1, 1, 0, 2'd0, 4'b0000);
    cycle(0, 0, 1, 1, 2'd3, 4'b1111);
    cycle(0, 1, 0, 0, 2'd0, 4'b0000);

    // Random traffic with occasional run drops and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] h;
      for (int b = 0; b < 4; b++) h[b] = ($urandom_range(0, 9) == 0);
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 249) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            2'($urandom_range(0, 3)),
            h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
